// File: rtl/alu_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_pkg
//  Description : Shared encodings for the iterative ALU compare stage:
//                compare function codes, FSM states, slice relation and
//                the relation-to-flag decode.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_cmp_pkg;

    // Compare function codes carried on the fun port
    localparam logic [2:0] CMP_NE  = 3'b000;
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b010;
    localparam logic [2:0] CMP_GE  = 3'b011;
    localparam logic [2:0] CMP_LE  = 3'b100;
    localparam logic [2:0] CMP_LTZ = 3'b101;
    localparam logic [2:0] CMP_LEZ = 3'b110;
    localparam logic [2:0] CMP_GTZ = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Relation of operand A to operand B once a decisive slice is found
    typedef enum logic [1:0] {
        REL_LT = 2'd0,
        REL_EQ = 2'd1,
        REL_GT = 2'd2
    } rel_t;

    // Functions that compare A against zero; B is replaced by 0 at capture
    function automatic logic is_zero_fun(input logic [2:0] fun);
        return (fun == CMP_LTZ) || (fun == CMP_LEZ) || (fun == CMP_GTZ);
    endfunction

    // Map the final relation onto the single result flag for a function
    function automatic logic decode_flag(input logic [2:0] fun, input rel_t rel);
        logic w_lt;
        logic w_eq;
        logic w_gt;
        logic w_flag;
        w_lt = (rel == REL_LT);
        w_eq = (rel == REL_EQ);
        w_gt = (rel == REL_GT);
        case (fun)
            CMP_EQ:  w_flag = w_eq;
            CMP_NE:  w_flag = !w_eq;
            CMP_LT:  w_flag = w_lt;
            CMP_LTZ: w_flag = w_lt;
            CMP_GE:  w_flag = !w_lt;
            CMP_LE:  w_flag = w_lt | w_eq;
            CMP_LEZ: w_flag = w_lt | w_eq;
            CMP_GTZ: w_flag = w_gt;
            default: w_flag = 1'b0;
        endcase
        return w_flag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmp_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_slice
//  Description : Combinational unsigned magnitude compare of one SLICE-bit
//                chunk of the operands. Exactly one of lt/eq/gt is high.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);

endmodule
`default_nettype wire

// File: rtl/alu_cmp_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_iter
//  Description : Multi-cycle WIDTH-bit compare. Operands are compared SLICE
//                bits per cycle starting from the most significant slice and
//                stopping at the first slice that differs. Signed compares
//                are turned into unsigned ones by flipping both MSBs when the
//                operands are captured. valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmp_iter
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       fun,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int            NSLICE = WIDTH / SLICE;
    localparam int            KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_TOP  = KW'(NSLICE - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_fun;
    logic [KW-1:0]      r_k;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;

    logic               w_accept;
    logic [WIDTH-1:0]   w_b_sel;
    logic [WIDTH-1:0]   w_a_cap;
    logic [WIDTH-1:0]   w_b_cap;
    logic [31:0]        w_base;
    logic [SLICE-1:0]   w_xs;
    logic [SLICE-1:0]   w_ys;
    logic               w_lt;
    logic               w_eq;
    logic               w_gt;
    logic               w_decisive;
    rel_t               w_rel;

    // Accept when idle, or when the current result leaves on this very edge;
    // flush blocks acceptance outright.
    assign in_ready = !flush &&
                      ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    // Zero-compare functions ignore B; signed mode moves to offset binary so
    // every later slice compare can be plain unsigned.
    assign w_b_sel  = is_zero_fun(fun) ? '0 : b;
    assign w_a_cap  = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
    assign w_b_cap  = {w_b_sel[WIDTH-1] ^ sgn, w_b_sel[WIDTH-2:0]};

    // Select the slice currently under comparison
    assign w_base   = 32'(r_k) * 32'(SLICE);
    assign w_xs     = r_a[w_base +: SLICE];
    assign w_ys     = r_b[w_base +: SLICE];

    alu_cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .x  (w_xs),
        .y  (w_ys),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    // A differing slice settles the answer; an equal last slice means EQ
    assign w_decisive = !w_eq || (r_k == '0);
    assign w_rel      = w_lt ? REL_LT : (w_gt ? REL_GT : REL_EQ);

    // Operand, function and slice-index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_fun <= CMP_NE;
            r_k   <= '0;
        end else if (w_accept) begin
            r_a   <= w_a_cap;
            r_b   <= w_b_cap;
            r_fun <= fun;
            r_k   <= K_TOP;
        end else if ((r_state == ST_RUN) && !flush && !w_decisive) begin
            r_k   <= r_k - KW'(1);
        end
    end

    // Control FSM with registered out_valid and result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_decisive) begin
                        r_result    <= WIDTH'(decode_flag(r_fun, w_rel));
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? ST_RUN : ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire
